ps2_key_tracker: RTL
====================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning the number of simultaneously tracked keys (range 2..16).
REQ-002 SHALL have parameter PREFIX_TIMEOUT, default 2_500_000, meaning the number of idle cycles after which a pending prefix is abandoned.
REQ-003 SHALL have parameters UP_CODE, DOWN_CODE, LEFT_CODE and RIGHT_CODE, defaults 8'h73, 8'h72, 8'h69 and 8'h7A, meaning the direction scan codes.
REQ-004 SHALL have port CLOCK_50 input 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port resetn input 1, the reset; asynchronous, active-low.
REQ-006 SHALL have port ps2_key_data input 8, the received byte from PS2_Controller.
REQ-007 SHALL have port ps2_key_pressed input 1, a one-cycle strobe qualifying ps2_key_data.
REQ-008 SHALL have port clear input 1, a synchronous flush of all slots and flags.
REQ-009 SHALL have port slot_valid output NUM_SLOTS, where bit i means slot i holds a held key.
REQ-010 SHALL have port slot_code output 9*NUM_SLOTS, where slot i is {ext, code[7:0]} at bits [9i+8:9i].
REQ-011 SHALL have port key_count output $clog2(NUM_SLOTS+1), the number of valid slots.
REQ-012 SHALL have port dir output 4, the held levels {right, left, down, up}.
REQ-013 SHALL have port key_event output 1, a one-cycle strobe on every accepted make or break.
REQ-014 SHALL have port event_make output 1, which is 1 for make and 0 for break, valid with key_event.
REQ-015 SHALL have port event_code output 9, the {ext, code} of the event, valid with key_event.
REQ-016 SHALL have port overflow output 1, a sticky flag meaning a make was dropped because no slot was free.

Function
REQ-017 The decoder FSM SHALL have the states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen); the FSM advances only on ps2_key_pressed.
REQ-018 In IDLE: byte E0 -> EXT; byte F0 -> BRK; bytes 00/AA/EE/FA/FE/FF -> ignored, stay in IDLE; any other byte -> make(code, ext=0), stay in IDLE.
REQ-019 In EXT: byte F0 -> EXT_BRK; byte E0 -> stay in EXT; any other byte -> make(code, ext=1), then IDLE.
REQ-020 In BRK: any byte -> break(code, ext=0), then IDLE. In EXT_BRK: any byte -> break(code, ext=1), then IDLE.
REQ-021 On make, if a valid slot already holds an equal {ext, code} (typematic repeat), the block SHALL change no slot and raise no key_event.
REQ-022 On make of a new key, the block SHALL write the lowest-index free slot and pulse key_event with event_make=1.
REQ-023 On make with all slots full, the block SHALL change no slot, set overflow, and raise no key_event.
REQ-024 On break, the block SHALL clear the matching slot and pulse key_event with event_make=0; a break with no matching slot SHALL be ignored without an event.
REQ-025 For a strobe at cycle t, slot_valid, slot_code and key_event SHALL update at t+1.
REQ-026 For a strobe at cycle t, key_count and dir SHALL update at t+2 (registered from the slot state).
REQ-027 dir bit k SHALL be 1 while any valid slot has code equal to its direction parameter; the ext bit is ignored for this comparison.
REQ-028 In EXT, BRK or EXT_BRK, a 32-bit timeout counter SHALL count idle cycles; on reaching PREFIX_TIMEOUT the FSM SHALL return to IDLE with no slot change; the counter SHALL clear on every strobe and whenever the FSM is in IDLE.
REQ-029 clear=1 SHALL invalidate all slots, clear overflow and set the FSM to IDLE at the next edge; it SHALL take priority over a same-cycle strobe, whose byte is discarded.
REQ-030 A make and a break cannot occur in the same cycle, because the block accepts one byte per strobe; back-to-back strobes on consecutive cycles SHALL each be processed.

Reset
REQ-031 While resetn=0, the FSM SHALL be IDLE, all slots invalid with code 0, and key_count, dir, key_event, event_make, event_code, overflow and the timeout counter all 0.
REQ-032 A reset asserted mid-sequence (for example after E0 F0) SHALL abandon the sequence; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-033 The package ps2_pkg SHALL hold the prefix constants (E0, F0), the ignore-list bytes, the default direction codes and the FSM state encoding.
REQ-034 The block SHALL contain one sub-module, ps2_prefix_decoder, comprising the FSM and the timeout logic, which outputs a make/break strobe with {ext, code}; ps2_key_tracker SHALL hold the slot table, the counting logic and the output logic.

Verification
REQ-035 Byte sequence 1C, F0 1C -> slot0={0,1C} valid at t+1 with an event make; after F0 1C slot0 becomes invalid with an event break, and key_count returns to 0.
REQ-036 Sequence 73, 69, then 73 repeated 5 times -> slot0=73 and slot1=69, dir=4'b0101 at t+2, exactly 2 key_events, key_count=2.
REQ-037 Sequence E0 75, then 75 -> slot0={1,75} and slot1={0,75}; E0 F0 75 clears only slot0.
REQ-038 With NUM_SLOTS=4, makes 15 1D 24 2D 2C -> four slots filled, overflow=1, no fifth event; clear -> all slots invalid and overflow=0.
REQ-039 E0 followed by PREFIX_TIMEOUT idle cycles, then 1C -> a make {0,1C}, not {1,1C}.
REQ-040 Deassert resetn after F0 with no further byte, then 1C -> a make {0,1C}; a same-cycle clear and strobe -> the byte is dropped.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker.
// Prefix bytes, ignored controller bytes, direction codes, FSM states.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] IGN_ERR0 = 8'h00;
  localparam logic [7:0] IGN_BAT  = 8'hAA;
  localparam logic [7:0] IGN_ECHO = 8'hEE;
  localparam logic [7:0] IGN_ACK  = 8'hFA;
  localparam logic [7:0] IGN_RSND = 8'hFE;
  localparam logic [7:0] IGN_ERR1 = 8'hFF;

  localparam logic [7:0] DEF_UP_CODE    = 8'h73;
  localparam logic [7:0] DEF_DOWN_CODE  = 8'h72;
  localparam logic [7:0] DEF_LEFT_CODE  = 8'h69;
  localparam logic [7:0] DEF_RIGHT_CODE = 8'h7A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  function automatic logic is_ignored(
    input logic [7:0] b
  );
    return (b == IGN_ERR0) ||
           (b == IGN_BAT)  ||
           (b == IGN_ECHO) ||
           (b == IGN_ACK)  ||
           (b == IGN_RSND) ||
           (b == IGN_ERR1);
  endfunction

endpackage

// File: rtl/ps2_prefix_decoder.sv
// Scan-code prefix FSM: turns E0/F0 byte sequences into
// make/break strobes with {ext, code}, with a stale-prefix timeout.
module ps2_prefix_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] data,
  input  logic       strobe,
  output logic       make,
  output logic       brk,
  output key_t       key
);

  dec_state_t  state;
  dec_state_t  nxt;
  logic [31:0] tmo_cnt;
  logic [31:0] tmo_inc;
  logic        take;

  assign take    = strobe && !clear;
  assign tmo_inc = tmo_cnt + 32'd1;

  // Strobes are combinational so the slot table can register them
  // on the very edge that samples the byte.
  always_comb begin
    nxt      = state;
    make     = 1'b0;
    brk      = 1'b0;
    key.ext  = 1'b0;
    key.code = data;
    if (take) begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            (data == PFX_EXT): nxt = ST_EXT;
            (data == PFX_BRK): nxt = ST_BRK;
            is_ignored(data): begin
            end
            default: make = 1'b1;
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            (data == PFX_BRK): nxt = ST_EXT_BRK;
            (data == PFX_EXT): nxt = ST_EXT;
            default: begin
              make    = 1'b1;
              key.ext = 1'b1;
              nxt     = ST_IDLE;
            end
          endcase
        end
        ST_BRK: begin
          brk = 1'b1;
          nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk     = 1'b1;
          key.ext = 1'b1;
          nxt     = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (clear) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (strobe) begin
      state   <= nxt;
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (tmo_inc == PREFIX_TIMEOUT) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_inc;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks currently held PS/2 keys in a small slot table and
// reports make/break events, held count and arrow-key levels.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
  parameter logic [7:0]  UP_CODE        = DEF_UP_CODE,
  parameter logic [7:0]  DOWN_CODE      = DEF_DOWN_CODE,
  parameter logic [7:0]  LEFT_CODE      = DEF_LEFT_CODE,
  parameter logic [7:0]  RIGHT_CODE     = DEF_RIGHT_CODE,
  localparam int unsigned CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic [7:0]             ps2_key_data,
  input  logic                   ps2_key_pressed,
  input  logic                   clear,
  output logic [NUM_SLOTS-1:0]   slot_valid,
  output logic [9*NUM_SLOTS-1:0] slot_code,
  output logic [CW-1:0]          key_count,
  output logic [3:0]             dir,
  output logic                   key_event,
  output logic                   event_make,
  output logic [8:0]             event_code,
  output logic                   overflow
);

  localparam int unsigned IW = $clog2(NUM_SLOTS);

  logic           dec_make;
  logic           dec_brk;
  key_t           dec_key;

  logic [NUM_SLOTS-1:0] valid_q;
  key_t                 code_q [NUM_SLOTS];

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          free;
  logic [IW-1:0] free_idx;
  logic [CW-1:0] cnt_c;
  logic [3:0]    dir_c;

  ps2_prefix_decoder #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_dec (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .clear (clear),
    .data  (ps2_key_data),
    .strobe(ps2_key_pressed),
    .make  (dec_make),
    .brk   (dec_brk),
    .key   (dec_key)
  );

  // A key never occupies two slots, so at most one slot can hit.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_q[i] && (code_q[i] == dec_key)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      key_event  <= 1'b0;
      event_make <= 1'b0;
      event_code <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        code_q[i] <= '0;
      end
    end else begin
      key_event <= 1'b0;
      if (clear) begin
        valid_q  <= '0;
        overflow <= 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          code_q[i] <= '0;
        end
      end else if (dec_make && !hit) begin
        if (free) begin
          valid_q[free_idx] <= 1'b1;
          code_q[free_idx]  <= dec_key;
          key_event         <= 1'b1;
          event_make        <= 1'b1;
          event_code        <= dec_key;
        end else begin
          overflow <= 1'b1;
        end
      end else if (dec_brk && hit) begin
        valid_q[hit_idx] <= 1'b0;
        code_q[hit_idx]  <= '0;
        key_event        <= 1'b1;
        event_make       <= 1'b0;
        event_code       <= dec_key;
      end
    end
  end

  // Direction match deliberately ignores the ext bit.
  always_comb begin
    cnt_c = '0;
    dir_c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_q[i]) begin
        cnt_c = cnt_c + CW'(1);
        if (code_q[i].code == UP_CODE)    dir_c[0] = 1'b1;
        if (code_q[i].code == DOWN_CODE)  dir_c[1] = 1'b1;
        if (code_q[i].code == LEFT_CODE)  dir_c[2] = 1'b1;
        if (code_q[i].code == RIGHT_CODE) dir_c[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_count <= '0;
      dir       <= '0;
    end else begin
      key_count <= cnt_c;
      dir       <= dir_c;
    end
  end

  assign slot_valid = valid_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_code
    assign slot_code[9*g +: 9] = code_q[g];
  end

endmodule
